// File: rtl/zx_ula_io.sv
// zx_ula_io: ZX Spectrum keyboard/port xxFE I/O and 50 Hz frame interrupt.
//
// Debounces NUM_KEYS board buttons and places each one on the 8x5 Spectrum
// keyboard matrix using KEY_MAP (6 bits per key: [5:3] row, [2:0] column).
// Answers Z80 IN from any even port, latches border/MIC/beeper on OUT to any
// even port, and generates the frame interrupt on int_n.
//
// Ports:
//   clk, resetn         system clock (rising edge), async active-low reset
//   btn[NUM_KEYS]       raw asynchronous button pins
//   ad[15:0]            CPU address bus (A8..A15 select keyboard rows)
//   iorq_n,m1_n,rd_n,wr_n  Z80 bus control strobes
//   data_bus[7:0]       shared tri-state CPU data bus
//   int_n               registered Z80 INT
//   frame_tick          one-cycle pulse at frame start
//   flash               toggles every 16 frames
//   border[2:0],mic,beeper  latched from port xxFE writes
module zx_ula_io #(
  parameter int                    NUM_KEYS        = 5,
  parameter logic [6*NUM_KEYS-1:0] KEY_MAP         = {NUM_KEYS{6'b000_000}},
  parameter int                    BTN_ACTIVE_LOW  = 1,
  parameter int                    DEBOUNCE_CYCLES = 65536,
  parameter int                    FRAME_CYCLES    = 540000,
  parameter int                    INT_LEN         = 864,
  parameter int                    INT_MODE        = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] btn,
  input  logic [15:0]         ad,
  input  logic                iorq_n,
  input  logic                m1_n,
  input  logic                rd_n,
  input  logic                wr_n,
  inout  wire  [7:0]          data_bus,
  output logic                int_n,
  output logic                frame_tick,
  output logic                flash,
  output logic [2:0]          border,
  output logic                mic,
  output logic                beeper
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FC_W = $clog2(FRAME_CYCLES);
  localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0]     FC_LAST  = FC_W'(FRAME_CYCLES - 1);
  localparam logic [FC_W-1:0]     INT_END  = FC_W'(INT_LEN);
  localparam logic                BTN_INV  = (BTN_ACTIVE_LOW != 0);
  localparam logic [NUM_KEYS-1:0] BTN_IDLE = {NUM_KEYS{BTN_INV}};

  function automatic logic [2:0] key_row(input int i);
    return KEY_MAP[6*i+3 +: 3];
  endfunction

  function automatic logic [2:0] key_col(input int i);
    return KEY_MAP[6*i +: 3];
  endfunction

  // Stage p0/p1: two-flop synchroniser on the raw pins
  logic [NUM_KEYS-1:0] sync_p0, sync_p1;
  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] key_stable;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= BTN_IDLE;
      sync_p1 <= BTN_IDLE;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // 1 = pressed, whatever the pin polarity
  assign key_lvl = sync_p1 ^ BTN_IDLE;

  // Debounce: a level must disagree with the stable state for
  // DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_stable <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_lvl[i] == key_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_stable[i] <= key_lvl[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Keyboard matrix read: a row is selected by a low address line A8+row;
  // any pressed key on a selected row pulls its column low.
  logic [7:0] row_sel_n;
  logic [4:0] col_n;
  logic       ula_sel;

  assign row_sel_n = ad[15:8];
  assign ula_sel   = !iorq_n && m1_n && !ad[0];

  always_comb begin
    col_n = '1;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_stable[i] && (key_col(i) < 3'd5) && !row_sel_n[key_row(i)])
        col_n[key_col(i)] = 1'b0;
    end
  end

  assign data_bus = (ula_sel && !rd_n) ? {3'b111, col_n} : 8'hzz;

  // Port write: capture only on the first cycle of an access
  logic wr_req, wr_req_p0;
  assign wr_req = ula_sel && !wr_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_req_p0 <= 1'b0;
      border    <= '0;
      mic       <= 1'b0;
      beeper    <= 1'b0;
    end else begin
      wr_req_p0 <= wr_req;
      if (wr_req && !wr_req_p0) begin
        border <= data_bus[2:0];
        mic    <= data_bus[3];
        beeper <= data_bus[4];
      end
    end
  end

  // Frame timing and interrupt FSM
  typedef enum logic {IRQ_IDLE, IRQ_ACTIVE} irq_state_t;

  irq_state_t      state, state_nxt;
  logic            int_n_nxt;
  logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;
  logic            frame_wrap;
  logic            int_ack;
  logic [3:0]      flash_cnt;

  assign frame_wrap    = (frame_cnt == FC_LAST);
  assign frame_cnt_nxt = frame_wrap ? '0 : frame_cnt + 1'b1;
  assign int_ack       = !m1_n && !iorq_n;

  always_comb begin
    state_nxt = state;
    int_n_nxt = 1'b1;
    case (state)
      IRQ_IDLE: begin
        if (frame_wrap) state_nxt = IRQ_ACTIVE;
      end
      IRQ_ACTIVE: begin
        // Early release on acknowledge only in acknowledge-terminated mode
        if ((frame_cnt_nxt == INT_END) || ((INT_MODE != 0) && int_ack))
          state_nxt = IRQ_IDLE;
      end
      default: state_nxt = IRQ_IDLE;
    endcase
    if (state_nxt == IRQ_ACTIVE) int_n_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IRQ_IDLE;
      int_n      <= 1'b1;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      flash_cnt  <= '0;
      flash      <= 1'b0;
    end else begin
      state      <= state_nxt;
      int_n      <= int_n_nxt;
      frame_tick <= frame_wrap;
      frame_cnt  <= frame_cnt_nxt;
      if (frame_wrap) begin
        flash_cnt <= flash_cnt + 1'b1;
        if (flash_cnt == 4'hF) flash <= ~flash;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ad[7:1], data_bus[7:5]};

endmodule

// File: tb/tb_zx_ula_io.sv
module tb_zx_ula_io;
  localparam int FRAME = 100;
  localparam int ILEN  = 8;
  localparam int DEB   = 4;
  localparam int NK    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  // DUT 0: fixed-length interrupt, keyboard and port tests
  logic [NK-1:0] btn0;
  logic [15:0]   ad0;
  logic          iorq0_n, m1_0_n, rd0_n, wr0_n;
  logic [7:0]    drv0;
  logic          oe0;
  wire  [7:0]    bus0;
  logic          int0_n, tick0, flash0, mic0, beep0;
  logic [2:0]    border0;
  assign bus0 = oe0 ? drv0 : 8'hzz;

  // DUT 1: acknowledge-terminated interrupt
  logic [NK-1:0] btn1;
  logic [15:0]   ad1;
  logic          iorq1_n, m1_1_n, rd1_n, wr1_n;
  logic          oe1;
  wire  [7:0]    bus1;
  logic          int1_n, tick1, flash1, mic1, beep1;
  logic [2:0]    border1;
  assign bus1 = oe1 ? 8'h00 : 8'hzz;

  zx_ula_io #(
    .NUM_KEYS(NK),
    .KEY_MAP({6'b001_110, 6'b111_100, 6'b011_010, 6'b000_000, 6'b110_000}),
    .BTN_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
    .FRAME_CYCLES(FRAME), .INT_LEN(ILEN), .INT_MODE(0)
  ) u_dut0 (
    .clk(clk), .resetn(resetn), .btn(btn0), .ad(ad0), .iorq_n(iorq0_n),
    .m1_n(m1_0_n), .rd_n(rd0_n), .wr_n(wr0_n), .data_bus(bus0),
    .int_n(int0_n), .frame_tick(tick0), .flash(flash0), .border(border0),
    .mic(mic0), .beeper(beep0)
  );

  zx_ula_io #(
    .NUM_KEYS(NK), .BTN_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
    .FRAME_CYCLES(FRAME), .INT_LEN(ILEN), .INT_MODE(1)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .btn(btn1), .ad(ad1), .iorq_n(iorq1_n),
    .m1_n(m1_1_n), .rd_n(rd1_n), .wr_n(wr1_n), .data_bus(bus1),
    .int_n(int1_n), .frame_tick(tick1), .flash(flash1), .border(border1),
    .mic(mic1), .beeper(beep1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Edges since the last reset release
  int cyc = 0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Reference model state
  int         km_row [NK] = '{6, 0, 3, 7, 1};
  int         km_col [NK] = '{0, 0, 2, 4, 6};
  bit         pressed [NK];
  logic [4:0] out_model = '0;   // {beeper, mic, border}

  function automatic logic [7:0] model_read(input logic [15:0] a);
    logic [7:0] v;
    v = 8'hFF;
    for (int i = 0; i < NK; i++)
      if (pressed[i] && km_col[i] < 5 && a[8 + km_row[i]] == 1'b0)
        v[km_col[i]] = 1'b0;
    return v;
  endfunction

  // Scoreboard: kind 0 bus, 1 {beeper,mic,border}, 2 flash, 3 int_n, 4 frame_tick
  typedef struct { string name; int kind; logic [31:0] exp; } exp_t;
  exp_t sbq[$];

  task automatic push(input string nm, input int kind, input logic [31:0] exp);
    exp_t e;
    e.name = nm; e.kind = kind; e.exp = exp;
    sbq.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = sbq.pop_front();
        act = '0;
        case (e.kind)
          0: act[7:0] = bus0;
          1: act[4:0] = {beep0, mic0, border0};
          2: act[0]   = flash0;
          3: act[0]   = int0_n;
          default: act[0] = tick0;
        endcase
        check(e.name, act, e.exp);
      end
    end
  end

  // Interrupt monitor, fixed-length instance
  int np0 = 0;
  initial begin
    int fall;
    bit prev;
    fall = 0; prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev = 1'b1; np0 = 0;
      end else begin
        if (prev && !int0_n) begin
          np0++; fall = cyc;
          check("int0_fall_cycle", cyc, np0 * FRAME);
          check("int0_tick_at_fall", tick0, 1);
        end else if (!prev && int0_n) begin
          check("int0_low_len", cyc - fall, ILEN);
        end else if (tick0) begin
          check("int0_stray_tick", tick0, 0);
        end
        prev = int0_n;
      end
    end
  end

  // Interrupt monitor, acknowledge-terminated instance
  int np1 = 0;
  initial begin
    int fall, ackk, explen;
    bit prev;
    fall = 0; ackk = -1; prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev = 1'b1; np1 = 0;
      end else begin
        if (prev && !int1_n) begin
          np1++; fall = cyc; ackk = -1;
          check("int1_fall_cycle", cyc, np1 * FRAME);
          check("int1_tick_at_fall", tick1, 1);
        end else if (!prev && int1_n) begin
          explen = (ackk >= 0 && ackk + 1 < ILEN) ? ackk + 1 : ILEN;
          check("int1_low_len", cyc - fall, explen);
        end
        if (!int1_n && ackk < 0 && !m1_1_n && !iorq1_n) ackk = cyc - fall;
        prev = int1_n;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 6000) begin step(1); guard++; end
    if (cyc < t) check("wait_cyc_timeout", cyc, t);
  endtask

  task automatic idle0();
    ad0 = 16'h0000; iorq0_n = 1'b1; m1_0_n = 1'b1; rd0_n = 1'b1; wr0_n = 1'b1;
    oe0 = 1'b0; drv0 = 8'h00;
  endtask

  task automatic rd_ula(input logic [15:0] a, input string nm);
    ad0 = a; iorq0_n = 1'b0; m1_0_n = 1'b1; rd0_n = 1'b0; wr0_n = 1'b1; oe0 = 1'b0;
    push(nm, 0, {24'h0, model_read(a)});
    step(1);
    idle0();
  endtask

  // Non-ULA access: bench drives a probe that must come back undisturbed
  task automatic rd_probe(input logic [15:0] a, input logic m1, input logic rd,
                          input logic [7:0] p, input string nm);
    ad0 = a; iorq0_n = 1'b0; m1_0_n = m1; rd0_n = rd; wr0_n = 1'b1;
    drv0 = p; oe0 = 1'b1;
    push(nm, 0, {24'h0, p});
    step(1);
    idle0();
  endtask

  task automatic wr_cycle(input logic [15:0] a, input logic [7:0] d, input int hold,
                          input string nm);
    ad0 = a; drv0 = d; oe0 = 1'b1; iorq0_n = 1'b0; m1_0_n = 1'b1; wr0_n = 1'b0; rd0_n = 1'b1;
    if (!a[0]) out_model = {d[4], d[3], d[2:0]};
    step(1);
    push({nm, "_first"}, 1, {27'h0, out_model});
    push({nm, "_bus"}, 0, {24'h0, d});
    step(1);
    drv0 = ~d;
    step(hold - 2);
    push({nm, "_held"}, 1, {27'h0, out_model});
    step(1);
    idle0();
    step(1);
  endtask

  // Acknowledge stimulus for the mode-1 instance
  initial begin
    int kk, guard;
    iorq1_n = 1'b1; m1_1_n = 1'b1; ad1 = 16'h0000; rd1_n = 1'b1; wr1_n = 1'b1;
    oe1 = 1'b0; btn1 = '1;
    #1;
    guard = 0;
    while (!resetn && guard < 100) begin step(1); guard++; end
    for (int p = 0; p < 4; p++) begin
      guard = 0;
      while (int1_n && guard < 3 * FRAME) begin step(1); guard++; end
      if (int1_n) check("int1_fall_timeout", int1_n, 0);
      case (p)
        0: kk = 2;
        1: kk = -1;
        2: kk = $urandom_range(0, 6);
        default: kk = $urandom_range(7, 10);
      endcase
      if (kk >= 0) begin
        step(kk);
        iorq1_n = 1'b0; m1_1_n = 1'b0;
        step(1);
        iorq1_n = 1'b1; m1_1_n = 1'b1;
      end
      guard = 0;
      while (!int1_n && guard < 3 * FRAME) begin step(1); guard++; end
      step(20);
      // Acknowledge while idle must not affect anything
      iorq1_n = 1'b0; m1_1_n = 1'b0;
      step(1);
      iorq1_n = 1'b1; m1_1_n = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [15:0] a;
    logic [7:0]  d8;
    resetn = 1'b0;
    btn0 = '1;
    idle0();
    for (int i = 0; i < NK; i++) pressed[i] = 1'b0;
    step(3);
    // Reset state
    oe0 = 1'b1; drv0 = 8'hA5;
    push("reset_bus_hiz", 0, 32'hA5);
    push("reset_outs", 1, 32'h0);
    push("reset_flash", 2, 32'h0);
    push("reset_int_n", 3, 32'h1);
    push("reset_tick", 4, 32'h0);
    step(1);
    idle0();
    resetn = 1'b1;

    // Exact debounce latency for key0 (row 6, col 0)
    rd_ula(16'h00FE, "idle_read_all_released");
    ad0 = 16'hBFFE; iorq0_n = 1'b0; rd0_n = 1'b0;
    btn0[0] = 1'b0;
    step(5);
    push("key0_before_debounce", 0, 32'hFF);
    step(1);
    push("key0_after_debounce", 0, 32'hFE);
    pressed[0] = 1'b1;
    step(1);
    idle0();
    rd_ula(16'hBFFE, "key0_row6");
    rd_ula(16'hFEFE, "key0_row0_only");
    rd_ula(16'h00FE, "key0_all_rows");
    btn0[0] = 1'b1;
    step(8);
    pressed[0] = 1'b0;
    rd_ula(16'hBFFE, "key0_released");

    // Glitches shorter than the debounce window
    for (int g = 0; g < 3; g++) begin
      btn0[0] = 1'b0; step(2); btn0[0] = 1'b1; step(2);
    end
    btn0[0] = 1'b0; step(3); btn0[0] = 1'b1; step(8);
    rd_ula(16'hBFFE, "glitch_ignored");

    // Two keys on column 0, rows 0 and 6
    btn0[1] = 1'b0; step(8); pressed[1] = 1'b1;
    rd_ula(16'hBFFE, "key1_row6_sel");
    rd_ula(16'h00FE, "key1_all_rows");
    rd_ula(16'hFEFE, "key1_row0_sel");
    btn0 = '1; step(8);
    for (int i = 0; i < NK; i++) pressed[i] = 1'b0;

    // Random key patterns and row selections
    for (int it = 0; it < 10; it++) begin
      r = $urandom;
      btn0 = r[NK-1:0];
      step(8);
      for (int i = 0; i < NK; i++) pressed[i] = !btn0[i];
      for (int k = 0; k < 3; k++) begin
        r = $urandom;
        a = {r[15:1], 1'b0};
        rd_ula(a, "rand_read");
      end
      r = $urandom;
      rd_probe({r[15:1], 1'b1}, 1'b1, 1'b0, r[23:16], "odd_port_read_hiz");
    end
    rd_probe(16'h00FE, 1'b0, 1'b0, 8'h3C, "m1_read_hiz");
    btn0 = '1; step(8);
    for (int i = 0; i < NK; i++) pressed[i] = 1'b0;

    // Port writes
    wr_cycle(16'h00FE, 8'h17, 5, "wr_17");
    wr_cycle(16'h00FF, 8'h00, 3, "wr_odd");
    for (int it = 0; it < 6; it++) begin
      r = $urandom;
      a = {r[15:1], r[16]};
      d8 = 8'($urandom);
      wr_cycle(a, d8, 2 + int'(r[18:17]), "wr_rand");
    end
    wr_cycle(16'hFEFE, 8'h05, 2, "wr_05");

    // flash over 32 frames
    wait_cyc(850);
    push("flash_8_frames", 2, {31'h0, 1'(((cyc / FRAME) / 16) % 2)});
    wait_cyc(1650);
    push("flash_16_frames", 2, {31'h0, 1'(((cyc / FRAME) / 16) % 2)});
    wait_cyc(3250);
    push("flash_32_frames", 2, {31'h0, 1'(((cyc / FRAME) / 16) % 2)});
    step(1);
    check("int0_pulse_count", np0, cyc / FRAME);

    // Reset in the middle of an interrupt pulse
    wait_cyc(3303);
    #2;
    resetn = 1'b0;
    #1;
    out_model = '0;
    push("midpulse_reset_int_n", 3, 32'h1);
    push("midpulse_reset_outs", 1, 32'h0);
    step(3);
    resetn = 1'b1;
    rd_ula(16'h00FE, "post_reset_read");
    wait_cyc(260);
    check("int0_pulses_after_reset", np0, 2);
    check("int1_pulses_after_reset", np1, 2);
    step(2);
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
